parking_gate_controller: RTL and testbench
==========================================

# parking_gate_controller

Clocked gate-side controller that sits in front of the parking occupancy counter and produces its input events. It debounces the entry and exit vehicle sensors and latches the car-type flag. Entry is checked against the counter's vacancy flags. Each admitted or departing car produces exactly one `car_entered` or `car_exited` pulse, with the matching type flag held stable across the pulse's falling edge, where the counter samples it. It also drives the entry and exit barrier outputs.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized cycles a sensor must disagree with its debounced level before that level flips (≥1).
- `PULSE_CYCLES`, 2: high time of `car_entered` / `car_exited` (≥1).
- `GATE_CYCLES`, 16: minimum barrier-open time (≥1).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `entry_sensor` in 1: raw loop sensor at entry lane, async.
- `entry_is_uni` in 1: card reader at entry; 1 = university car; async, stable while car on loop.
- `exit_sensor` in 1: raw loop sensor at exit lane, async.
- `exit_is_uni` in 1: card reader at exit.
- `uni_is_vacated_space` in 1: vacancy flag from counter, same clock domain.
- `free_is_vacated_space` in 1: vacancy flag from counter, same clock domain.
- `car_entered` out 1: entry event pulse; counter acts on falling edge.
- `is_uni_car_entered` out 1: type of current/last entry event.
- `car_exited` out 1: exit event pulse; counter acts on falling edge.
- `is_uni_car_exited` out 1: type of current/last exit event.
- `entry_gate_open` out 1: entry barrier raised.
- `exit_gate_open` out 1: exit barrier raised.
- `entry_denied` out 1: "full" lamp for rejected entry.

## Operation
- All outputs are registered. Reset value of every output is 0. All FSMs reset to IDLE and all counters to 0.
- Sensor and card inputs each pass through a 2-flop synchronizer.
- Debounce: per sensor, a counter counts consecutive cycles where the synchronized value ≠ debounced level. It clears on agreement. When the count reaches DEBOUNCE_CYCLES, the debounced level flips on that edge and the count clears.
- A debounced rise is a 0→1 transition of the debounced level. It is consumed only in IDLE; rises in other states are ignored.
- Entry FSM: IDLE, CHECK, PULSE, HOLD, GATE, DENY.
  - IDLE: on debounced rise, latch synchronized `entry_is_uni` into `is_uni_car_entered`, then go to CHECK.
  - CHECK (1 cycle): if the latched type's vacancy flag is 1, go to PULSE; otherwise go to DENY. The uni type uses `uni_is_vacated_space`; the free type uses `free_is_vacated_space`.
  - PULSE: `car_entered`=1 for exactly PULSE_CYCLES cycles, then go to HOLD.
  - HOLD (1 cycle): `car_entered`=0 with type unchanged, then go to GATE.
  - GATE: `entry_gate_open`=1. Leave for IDLE when ≥GATE_CYCLES cycles have elapsed in GATE and the debounced sensor is 0.
  - DENY: `entry_denied`=1. Go to IDLE when the debounced sensor is 0; no pulse is issued.
- Exit FSM: IDLE, PULSE, HOLD, GATE. Identical to entry minus CHECK/DENY: IDLE goes directly to PULSE on debounced rise and latches `exit_is_uni`. Exits are never refused; the counter guards underflow.
- `is_uni_car_*` changes only when leaving IDLE on an accepted rise. It otherwise holds its last value.
- The entry and exit FSMs are fully independent. Simultaneous entry and exit pulses are legal, since the counter uses separate edges.

## Timing
- Raw sensor edge to debounced edge: 2 (sync) + DEBOUNCE_CYCLES cycles, given a stable raw input.
- Entry: debounced rise at edge N gives CHECK at N+1 and `car_entered` high at N+2 through N+1+PULSE_CYCLES. The falling edge is at N+2+PULSE_CYCLES, and the gate opens at N+3+PULSE_CYCLES.
- Exit: one cycle shorter. `car_exited` rises at N+1.
- The type flag is stable from ≥1 cycle before the pulse rises until after the gate closes.
- Vacancy flags are sampled only in the CHECK cycle. Later changes do not affect the decision.
- Sensor bounce shorter than DEBOUNCE_CYCLES produces no event. A car lingering in GATE or DENY produces no second event.
- Reset mid-pulse drops `car_*` asynchronously. The system reset also resets the counter, so any resulting edge is harmless. No event is replayed after reset.

## Test plan
- Clean uni entry, `uni_is_vacated_space`=1, defaults → exactly one `car_entered` pulse 2 cycles wide. `is_uni_car_entered`=1 across its falling edge. `entry_gate_open` lasts ≥16 cycles and drops once the sensor is clear.
- Free entry with `free_is_vacated_space`=0 → no `car_entered`. `entry_denied`=1 until the debounced sensor falls, then 0.
- Sensor glitch of 3 cycles (DEBOUNCE_CYCLES=4) → no pulse, no gate. A following 10-cycle hold → one pulse.
- Entry and exit rises debounced on the same edge → `car_exited` rises 1 cycle before `car_entered`. Both are 2 cycles wide with correct independent type flags.
- Car dwells 100 cycles on entry loop → a single pulse; gate stays open until clear.
- `rst` asserted during PULSE → all outputs 0 immediately. After release, no pulse until a fresh debounced rise.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Gate-side controller for the parking occupancy counter.
// Debounces the entry/exit loop sensors and latches the card type. It emits one
// car_entered / car_exited pulse per admitted or departing car and drives the barriers.

// Synchronizer plus debouncer for one loop sensor. The rise output is a
// one-cycle strobe that is registered on the same edge as the level flip.
module pgc_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The level flips on the CYCLES-th consecutive disagreeing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= ~level;
        rise  <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module parking_gate_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GATE_CYCLES     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_sensor,
  input  logic entry_is_uni,
  input  logic exit_sensor,
  input  logic exit_is_uni,
  input  logic uni_is_vacated_space,
  input  logic free_is_vacated_space,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied
);
  localparam int TMAX = (PULSE_CYCLES > GATE_CYCLES) ? PULSE_CYCLES : GATE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {E_IDLE, E_CHECK, E_PULSE, E_HOLD, E_GATE, E_DENY} ent_t;
  typedef enum logic [1:0] {X_IDLE, X_PULSE, X_HOLD, X_GATE} ext_t;

  logic ent_lvl, ent_rise, ext_lvl, ext_rise;
  logic [1:0] ent_uni_sync, ext_uni_sync;

  ent_t e_state, e_next;
  ext_t x_state, x_next;
  logic [TW-1:0] e_tmr, e_tmr_next, x_tmr, x_tmr_next;
  logic e_uni_next, x_uni_next;

  pgc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ent_db (
    .clk(clk), .rst(rst), .raw(entry_sensor), .level(ent_lvl), .rise(ent_rise));
  pgc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ext_db (
    .clk(clk), .rst(rst), .raw(exit_sensor), .level(ext_lvl), .rise(ext_rise));

  // Card-type inputs get the same 2-flop synchronizer as the sensors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_uni_sync <= '0;
      ext_uni_sync <= '0;
    end else begin
      ent_uni_sync <= {ent_uni_sync[0], entry_is_uni};
      ext_uni_sync <= {ext_uni_sync[0], exit_is_uni};
    end
  end

  // Entry next-state: the vacancy check uses the type already latched on leaving IDLE.
  always_comb begin
    e_next     = e_state;
    e_tmr_next = e_tmr;
    e_uni_next = is_uni_car_entered;
    case (e_state)
      E_IDLE: begin
        e_tmr_next = '0;
        if (ent_rise) begin
          e_next     = E_CHECK;
          e_uni_next = ent_uni_sync[1];
        end
      end
      E_CHECK: begin
        e_tmr_next = '0;
        e_next = (is_uni_car_entered ? uni_is_vacated_space : free_is_vacated_space)
                 ? E_PULSE : E_DENY;
      end
      E_PULSE: begin
        if (e_tmr == P_LAST) begin
          e_next     = E_HOLD;
          e_tmr_next = '0;
        end else begin
          e_tmr_next = e_tmr + 1'b1;
        end
      end
      E_HOLD: begin
        e_next     = E_GATE;
        e_tmr_next = '0;
      end
      E_GATE: begin
        if (e_tmr != G_LAST) e_tmr_next = e_tmr + 1'b1;
        if (e_tmr == G_LAST && !ent_lvl) e_next = E_IDLE;
      end
      E_DENY: begin
        if (!ent_lvl) e_next = E_IDLE;
      end
      default: e_next = E_IDLE;
    endcase
  end

  // Exit next-state: exits are never refused, so there is no CHECK or DENY.
  always_comb begin
    x_next     = x_state;
    x_tmr_next = x_tmr;
    x_uni_next = is_uni_car_exited;
    case (x_state)
      X_IDLE: begin
        x_tmr_next = '0;
        if (ext_rise) begin
          x_next     = X_PULSE;
          x_uni_next = ext_uni_sync[1];
        end
      end
      X_PULSE: begin
        if (x_tmr == P_LAST) begin
          x_next     = X_HOLD;
          x_tmr_next = '0;
        end else begin
          x_tmr_next = x_tmr + 1'b1;
        end
      end
      X_HOLD: begin
        x_next     = X_GATE;
        x_tmr_next = '0;
      end
      X_GATE: begin
        if (x_tmr != G_LAST) x_tmr_next = x_tmr + 1'b1;
        if (x_tmr == G_LAST && !ext_lvl) x_next = X_IDLE;
      end
      default: x_next = X_IDLE;
    endcase
  end

  // State, timers and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_state            <= E_IDLE;
      x_state            <= X_IDLE;
      e_tmr              <= '0;
      x_tmr              <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      entry_gate_open    <= 1'b0;
      exit_gate_open     <= 1'b0;
      entry_denied       <= 1'b0;
    end else begin
      e_state            <= e_next;
      x_state            <= x_next;
      e_tmr              <= e_tmr_next;
      x_tmr              <= x_tmr_next;
      car_entered        <= (e_next == E_PULSE);
      is_uni_car_entered <= e_uni_next;
      car_exited         <= (x_next == X_PULSE);
      is_uni_car_exited  <= x_uni_next;
      entry_gate_open    <= (e_next == E_GATE);
      exit_gate_open     <= (x_next == X_GATE);
      entry_denied       <= (e_next == E_DENY);
    end
  end
endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller at default parameters.
// A negedge monitor records pulse/gate timing; the directed tests compare that timing against hand-computed offsets.
module tb_parking_gate_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic entry_sensor = 0, entry_is_uni = 0, exit_sensor = 0, exit_is_uni = 0;
  logic uni_is_vacated_space = 0, free_is_vacated_space = 0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_gate_open, exit_gate_open, entry_denied;

  parking_gate_controller dut (
    .clk(clk), .rst(rst),
    .entry_sensor(entry_sensor), .entry_is_uni(entry_is_uni),
    .exit_sensor(exit_sensor), .exit_is_uni(exit_is_uni),
    .uni_is_vacated_space(uni_is_vacated_space),
    .free_is_vacated_space(free_is_vacated_space),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .entry_denied(entry_denied));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor (negedge sampling).
  int ent_pulses = 0, ent_rise_cyc = 0, ent_w = 0, ent_type_pre = 0, ent_type_fall = 0;
  int ext_pulses = 0, ext_rise_cyc = 0, ext_w = 0, ext_type_fall = 0;
  int eg_rises = 0, eg_rise_cyc = 0, eg_run = 0, eg_len = 0;
  int xg_run = 0, xg_len = 0, dn_run = 0, dn_len = 0;
  logic ent_prev = 0, ext_prev = 0, eg_prev = 0, xg_prev = 0, dn_prev = 0, ent_type_prev = 0;

  always @(negedge clk) begin
    if (car_entered) begin
      if (!ent_prev) begin
        ent_pulses++; ent_rise_cyc = cyc; ent_w = 0; ent_type_pre = int'(ent_type_prev);
      end
      ent_w++;
    end else if (ent_prev) ent_type_fall = int'(is_uni_car_entered);
    if (car_exited) begin
      if (!ext_prev) begin ext_pulses++; ext_rise_cyc = cyc; ext_w = 0; end
      ext_w++;
    end else if (ext_prev) ext_type_fall = int'(is_uni_car_exited);
    if (entry_gate_open) begin
      if (!eg_prev) begin eg_rises++; eg_rise_cyc = cyc; eg_run = 0; end
      eg_run++;
    end else if (eg_prev) eg_len = eg_run;
    if (exit_gate_open) begin
      if (!xg_prev) xg_run = 0;
      xg_run++;
    end else if (xg_prev) xg_len = xg_run;
    if (entry_denied) begin
      if (!dn_prev) dn_run = 0;
      dn_run++;
    end else if (dn_prev) dn_len = dn_run;
    ent_prev = car_entered; ext_prev = car_exited; eg_prev = entry_gate_open;
    xg_prev = exit_gate_open; dn_prev = entry_denied; ent_type_prev = is_uni_car_entered;
  end

  int t0, p0, g0, x0;

  initial begin
    // Reset state
    tick(3);
    chk("rst_outs", int'({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                          entry_gate_open, exit_gate_open, entry_denied}), 0);
    rst = 1'b0;
    tick(5);
    chk("idle_outs", int'({car_entered, car_exited, entry_gate_open, exit_gate_open,
                           entry_denied}), 0);

    // Clean uni entry with vacancy
    entry_is_uni = 1; uni_is_vacated_space = 1; free_is_vacated_space = 0;
    p0 = ent_pulses; t0 = cyc;
    entry_sensor = 1; tick(30); entry_sensor = 0; tick(40);
    chk("t1_pulses", ent_pulses - p0, 1);
    chk("t1_rise_ofs", ent_rise_cyc - t0, 8);
    chk("t1_width", ent_w, 2);
    chk("t1_type_pre", ent_type_pre, 1);
    chk("t1_type_fall", ent_type_fall, 1);
    chk("t1_gate_ofs", eg_rise_cyc - t0, 11);
    chk("t1_gate_len", eg_len, 26);
    chk("t1_gate_now", int'(entry_gate_open), 0);

    // Free entry with no free vacancy -> denied
    entry_is_uni = 0; free_is_vacated_space = 0;
    p0 = ent_pulses; g0 = eg_rises; t0 = cyc;
    entry_sensor = 1; tick(15);
    chk("t2_denied_on", int'(entry_denied), 1);
    tick(5); entry_sensor = 0; tick(20);
    chk("t2_pulses", ent_pulses - p0, 0);
    chk("t2_gate", eg_rises - g0, 0);
    chk("t2_deny_len", dn_len, 19);
    chk("t2_denied_off", int'(entry_denied), 0);
    chk("t2_type", int'(is_uni_car_entered), 0);

    // 3-cycle glitch, then a 10-cycle hold
    entry_is_uni = 1;
    p0 = ent_pulses; g0 = eg_rises;
    entry_sensor = 1; tick(3); entry_sensor = 0; tick(15);
    chk("t3_glitch_pulses", ent_pulses - p0, 0);
    chk("t3_glitch_gate", eg_rises - g0, 0);
    t0 = cyc;
    entry_sensor = 1; tick(10); entry_sensor = 0; tick(40);
    chk("t3_pulses", ent_pulses - p0, 1);
    chk("t3_rise_ofs", ent_rise_cyc - t0, 8);
    chk("t3_gate_len_min", eg_len, 16);

    // Simultaneous entry (free) and exit (uni)
    free_is_vacated_space = 1; entry_is_uni = 0; exit_is_uni = 1;
    p0 = ent_pulses; x0 = ext_pulses; t0 = cyc;
    entry_sensor = 1; exit_sensor = 1; tick(30);
    entry_sensor = 0; exit_sensor = 0; tick(40);
    chk("t4_ent_pulses", ent_pulses - p0, 1);
    chk("t4_ext_pulses", ext_pulses - x0, 1);
    chk("t4_ext_rise_ofs", ext_rise_cyc - t0, 7);
    chk("t4_ent_rise_ofs", ent_rise_cyc - t0, 8);
    chk("t4_ent_width", ent_w, 2);
    chk("t4_ext_width", ext_w, 2);
    chk("t4_ent_type", ent_type_fall, 0);
    chk("t4_ext_type", ext_type_fall, 1);
    chk("t4_ent_gate_len", eg_len, 26);
    chk("t4_ext_gate_len", xg_len, 27);

    // 100-cycle dwell
    entry_is_uni = 1;
    p0 = ent_pulses; t0 = cyc;
    entry_sensor = 1; tick(100); entry_sensor = 0; tick(40);
    chk("t5_pulses", ent_pulses - p0, 1);
    chk("t5_gate_len", eg_len, 96);

    // Reset during PULSE
    p0 = ent_pulses; t0 = cyc;
    entry_sensor = 1; tick(8);
    chk("t6_in_pulse", int'(car_entered), 1);
    #6 rst = 1'b1;
    #1;
    chk("t6_rst_outs", int'({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                             entry_gate_open, exit_gate_open, entry_denied}), 0);
    entry_sensor = 0; tick(3); rst = 1'b0; tick(30);
    chk("t6_no_replay", ent_pulses - p0, 1);
    t0 = cyc;
    entry_sensor = 1; tick(10); entry_sensor = 0; tick(40);
    chk("t6_fresh_pulses", ent_pulses - p0, 2);
    chk("t6_fresh_ofs", ent_rise_cyc - t0, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
